// File: rtl/ule_sar.sv
`default_nettype none
// ============================================================================
//  Module   : ule_sar
//  Purpose  : Successive-approximation search engine. Drives the trial operand
//             of an external unsigned less-or-equal comparator, reads back its
//             one-bit verdict and recovers the comparator's hidden operand B
//             (the largest code X with X <= B), one bit per step, MSB first.
//
//  Parameters
//    N       width of trial / result codes (>= 2)
//    SETTLE  cycles TRIAL is held stable before LE is sampled (>= 1)
//
//  Ports
//    CLK     in   1  clock, rising edge
//    RESETN  in   1  asynchronous active-low reset
//    START   in   1  request a search (sampled only while idle)
//    ABORT   in   1  cancel a running search (only with ULE_SAR_ABORT_EN)
//    TRIAL   out  N  registered code presented to comparator operand A
//    LE      in   1  comparator verdict, 1 when TRIAL <= B
//    BUSY    out  1  search in progress
//    DONE    out  1  one-cycle pulse, RESULT just updated
//    RESULT  out  N  last completed search value
//
//  Build option
//    ULE_SAR_ABORT_EN  adds the ABORT port and the cancel path.
//
//  Revision : 1.0  initial release
// ============================================================================
module ule_sar #(
    parameter int N      = 8,
    parameter int SETTLE = 1
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         START,
`ifdef ULE_SAR_ABORT_EN
    input  logic         ABORT,
`endif
    output logic [N-1:0] TRIAL,
    input  logic         LE,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] RESULT
);

    // Index and settle-counter widths never collapse to zero bits.
    localparam int J_W   = (N > 1)      ? $clog2(N)      : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [J_W-1:0]   J_MSB    = J_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N-1:0]     ONE      = N'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_STEP = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:0]   w_q;
    logic [J_W-1:0] j_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]   trial_q;
    logic [N-1:0]   result_q;
    logic           busy_q;
    logic           done_q;

    logic [N-1:0]   bit_mask;    // bit currently under test
    logic [N-1:0]   next_mask;   // bit tested by the following step
    logic [N-1:0]   w_d;         // working value once this step's verdict lands
    logic           sample_edge; // LE is consumed at this edge
    logic           abort_req;

    assign bit_mask    = ONE << j_q;
    assign next_mask   = bit_mask >> 1;
    assign w_d         = LE ? (w_q | bit_mask) : w_q;
    assign sample_edge = (cnt_q == CNT_LAST);

`ifdef ULE_SAR_ABORT_EN
    assign abort_req = ABORT;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            w_q      <= '0;
            j_q      <= '0;
            cnt_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // DONE is a pulse: any edge that does not complete a search clears it.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // While idle the comparator sees the last answer.
                    trial_q <= result_q;
                    if (START) begin
                        state_q <= S_STEP;
                        w_q     <= '0;
                        j_q     <= J_MSB;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        trial_q <= ONE << J_MSB;
                    end
                end

                S_STEP: begin
                    if (abort_req) begin
                        // Cancel wins over a coincident sample or completion;
                        // the partial value is dropped and RESULT is untouched.
                        state_q <= S_IDLE;
                        w_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        trial_q <= result_q;
                    end else if (!sample_edge) begin
                        // TRIAL stays put while the comparator settles.
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (j_q == '0) begin
                        // Last bit resolved: publish and return to idle.
                        state_q  <= S_IDLE;
                        result_q <= w_d;
                        trial_q  <= w_d;
                        w_q      <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        // Commit this bit and present the next trial at the
                        // same edge, so each step lasts exactly SETTLE cycles.
                        w_q     <= w_d;
                        j_q     <= j_q - J_W'(1);
                        cnt_q   <= '0;
                        trial_q <= w_d | next_mask;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TRIAL  = trial_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule
`default_nettype wire
